// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: stall bus encodings,
// reset polarity, FSM state encoding and the RUN-state decision helper.
package pipe_ctrl_pkg;

    localparam int STALL_BUS = 6;

    localparam logic STALL_ENABLE  = 1'b1;
    localparam logic STALL_DISABLE = 1'b0;
    localparam logic RST_ENABLE    = 1'b0;

    // Bit order is {wb, mem, ex, id, if, pc}; bit 0 stalls the PC.
    localparam logic [STALL_BUS-1:0] STALL_MEMW = 6'b011111;
    localparam logic [STALL_BUS-1:0] STALL_EXW  = 6'b001111;
    localparam logic [STALL_BUS-1:0] STALL_IDW  = 6'b000111;
    localparam logic [STALL_BUS-1:0] STALL_NONE = 6'b000000;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_EX_WAIT  = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    // Returns {ex_mc_done, ctrl_stall} for a cycle decided under RUN rules.
    function automatic logic [STALL_BUS:0] run_eval(input logic       memwait,
                                                    input logic       start,
                                                    input logic [5:0] n,
                                                    input logic       idreq);
        logic [STALL_BUS:0] r;
        r = {1'b0, STALL_NONE};
        if (memwait) begin
            r = {1'b0, STALL_MEMW};
        end else if (start && (n <= 6'd1)) begin
            r = {1'b1, (idreq ? STALL_IDW : STALL_NONE)};
        end else if (start) begin
            r = {1'b0, STALL_EXW};
        end else if (idreq) begin
            r = {1'b0, STALL_IDW};
        end else begin
            r = {1'b0, STALL_NONE};
        end
        return r;
    endfunction

    function automatic logic [5:0] dec_sat(input logic [5:0] v);
        return (v == 6'd0) ? 6'd0 : (v - 6'd1);
    endfunction

endpackage

// File: rtl/pipe_ctrl_stall_perf_cnt.sv
// Saturating count of cycles in which the PC is stalled.
// Present only when STALL_PERF_EN is defined.
`ifdef STALL_PERF_EN
module stall_perf_cnt
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    output logic [31:0] count_o
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    // Next count: advance on a stalled cycle, hold once all ones.
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule
`endif

// File: rtl/pipe_ctrl.sv
// Pipeline stall controller: load-use, multi-cycle EX and memory-wait stalls.
// Optional macro STALL_PERF_EN adds the perf_stall_cnt output.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_stallreq,
    input  logic                 ex_mc_start,
    input  logic [5:0]           ex_mc_cycles,
    input  logic                 mem_req,
    input  logic                 mem_ack,
`ifdef STALL_PERF_EN
    output logic [31:0]          perf_stall_cnt,
`endif
    output logic [STALL_BUS-1:0] ctrl_stall,
    output logic                 ex_mc_done,
    output logic                 busy
);

    state_e             state_q;
    state_e             state_d;
    logic [5:0]         cnt_q;
    logic [5:0]         cnt_d;
    logic               memwait_s;
    logic               eval_run_s;
    logic [STALL_BUS:0] out_s;

    assign memwait_s  = mem_req & ~mem_ack;
    // An acknowledged MEM_WAIT cycle is decided exactly like a RUN cycle.
    assign eval_run_s = (state_q == ST_RUN) || ((state_q == ST_MEM_WAIT) && mem_ack);

    // State and countdown registers.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q <= ST_RUN;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and countdown logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (eval_run_s) begin
            if (memwait_s) begin
                state_d = ST_MEM_WAIT;
            end else if (ex_mc_start && (ex_mc_cycles >= 6'd2)) begin
                state_d = ST_EX_WAIT;
                cnt_d   = ex_mc_cycles - 6'd2;
            end else begin
                state_d = ST_RUN;
            end
        end else if (state_q == ST_EX_WAIT) begin
            cnt_d = dec_sat(cnt_q);
            if (!memwait_s && (cnt_q == 6'd0)) begin
                state_d = ST_RUN;
            end else begin
                state_d = ST_EX_WAIT;
            end
        end else if (state_q == ST_MEM_WAIT) begin
            state_d = ST_MEM_WAIT;
        end else begin
            state_d = ST_RUN;
            cnt_d   = 6'd0;
        end
    end

    // Same-cycle stall vector and done pulse; silenced while reset is held.
    always_comb begin
        out_s = {1'b0, STALL_NONE};
        if (rst == RST_ENABLE) begin
            out_s = {1'b0, STALL_NONE};
        end else begin
            case (state_q)
                ST_RUN: begin
                    out_s = run_eval(memwait_s, ex_mc_start, ex_mc_cycles, id_stallreq);
                end
                ST_EX_WAIT: begin
                    if (memwait_s) begin
                        out_s = {1'b0, STALL_MEMW};
                    end else if (cnt_q != 6'd0) begin
                        out_s = {1'b0, STALL_EXW};
                    end else begin
                        out_s = {1'b1, STALL_NONE};
                    end
                end
                ST_MEM_WAIT: begin
                    if (!mem_ack) begin
                        out_s = {1'b0, STALL_MEMW};
                    end else begin
                        out_s = run_eval(1'b0, ex_mc_start, ex_mc_cycles, id_stallreq);
                    end
                end
                default: begin
                    out_s = {1'b0, STALL_NONE};
                end
            endcase
        end
    end

    assign ctrl_stall = out_s[STALL_BUS-1:0];
    assign ex_mc_done = out_s[STALL_BUS];
    assign busy       = (rst != RST_ENABLE) && (state_q != ST_RUN);

`ifdef STALL_PERF_EN
    stall_perf_cnt u_perf (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (ctrl_stall[0]),
        .count_o (perf_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a cycle-level reference model.
module tb_pipe_ctrl;

    localparam logic [5:0] MEMW = 6'b011111;
    localparam logic [5:0] EXW  = 6'b001111;
    localparam logic [5:0] IDW  = 6'b000111;
    localparam logic [5:0] NONE = 6'b000000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       id_stallreq = 1'b1;
    logic       ex_mc_start = 1'b1;
    logic [5:0] ex_mc_cycles = 6'd63;
    logic       mem_req = 1'b1;
    logic       mem_ack = 1'b1;
    logic [5:0] ctrl_stall;
    logic       ex_mc_done;
    logic       busy;
`ifdef STALL_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    bit armed = 1'b0;

    pipe_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_stallreq  (id_stallreq),
        .ex_mc_start  (ex_mc_start),
        .ex_mc_cycles (ex_mc_cycles),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
`ifdef STALL_PERF_EN
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .ctrl_stall   (ctrl_stall),
        .ex_mc_done   (ex_mc_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic lit(input string nm, input logic [5:0] es, input logic ed, input logic eb);
        chk(nm, {24'd0, busy, ex_mc_done, ctrl_stall}, {24'd0, eb, ed, es});
    endtask

    // Drive one cycle of inputs just after the edge, then wait to mid-cycle.
    task automatic step(input logic r, input logic idr, input logic st,
                        input logic [5:0] n, input logic mr, input logic ma);
        @(posedge clk);
        #1;
        rst = r; id_stallreq = idr; ex_mc_start = st;
        ex_mc_cycles = n; mem_req = mr; mem_ack = ma;
        @(negedge clk);
    endtask

    // Reference model: an EX op of length N started at age 0 finishes at the
    // first age >= N-1 that has no memory wait; a memory wait lasts until ack.
    bit          m_ex = 1'b0;
    bit          m_mem = 1'b0;
    int          m_age = 0;
    int          m_n = 0;
    bit          seen_rst = 1'b0;
    longint      m_perf = 0;

    always @(negedge clk) begin
        if (armed) begin
            logic [5:0] es;
            logic       ed;
            logic       eb;
            bit         mw;
            es = NONE; ed = 1'b0; eb = 1'b0;
            mw = mem_req && !mem_ack;
`ifdef STALL_PERF_EN
            if (seen_rst) chk("perf_model", perf_stall_cnt, m_perf[31:0]);
`endif
            if (!rst) begin
                m_ex = 1'b0; m_mem = 1'b0; m_age = 0;
                m_perf = 0; seen_rst = 1'b1;
            end else begin
                eb = m_ex || m_mem;
                if (m_ex) begin
                    if (mw) es = MEMW;
                    else if (m_age < m_n - 1) es = EXW;
                    else begin ed = 1'b1; m_ex = 1'b0; end
                    m_age++;
                end else if (m_mem && !mem_ack) begin
                    es = MEMW;
                end else begin
                    m_mem = 1'b0;
                    if (mw) begin
                        es = MEMW; m_mem = 1'b1;
                    end else if (ex_mc_start) begin
                        if (int'(ex_mc_cycles) <= 1) begin
                            ed = 1'b1;
                            es = id_stallreq ? IDW : NONE;
                        end else begin
                            es = EXW; m_ex = 1'b1; m_age = 1; m_n = int'(ex_mc_cycles);
                        end
                    end else if (id_stallreq) begin
                        es = IDW;
                    end
                end
                if (es[0] && m_perf < 64'hFFFF_FFFF) m_perf++;
            end
            chk("model", {24'd0, busy, ex_mc_done, ctrl_stall}, {24'd0, eb, ed, es});
        end
    end

    initial begin
        @(posedge clk);
        armed = 1'b1;
        // Reset held with every input high.
        step(1'b0, 1'b1, 1'b1, 6'd63, 1'b1, 1'b1); lit("rst_c1", NONE, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 6'd63, 1'b1, 1'b1); lit("rst_c2", NONE, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0); lit("run_idle", NONE, 1'b0, 1'b0);
        // Five-cycle EX op.
        step(1'b1, 1'b0, 1'b1, 6'd5, 1'b0, 1'b0); lit("ex5_c1", EXW, 1'b0, 1'b0);
        for (int i = 2; i <= 4; i++) begin
            step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0); lit("ex5_wait", EXW, 1'b0, 1'b1);
        end
        step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0); lit("ex5_done", NONE, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0); lit("ex5_after", NONE, 1'b0, 1'b0);
`ifdef STALL_PERF_EN
        chk("perf_ex5", perf_stall_cnt, 32'd4);
`endif
        // Memory wait of three cycles then ack.
        step(1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0); lit("mw_c1", MEMW, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0); lit("mw_c2", MEMW, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0); lit("mw_c3", MEMW, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 1'b1); lit("mw_ack", NONE, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0); lit("mw_after", NONE, 1'b0, 1'b0);
        // N=3 op stretched by a memory wait on cycles 2-6.
        step(1'b1, 1'b0, 1'b1, 6'd3, 1'b0, 1'b0); lit("ex3_c1", EXW, 1'b0, 1'b0);
        for (int i = 2; i <= 6; i++) begin
            step(1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0); lit("ex3_memw", MEMW, 1'b0, 1'b1);
        end
        step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0); lit("ex3_done", NONE, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0); lit("ex3_after", NONE, 1'b0, 1'b0);
        // Memory wait outranks a simultaneous EX start and load-use request.
        step(1'b1, 1'b1, 1'b1, 6'd4, 1'b1, 1'b0); lit("prio_memw", MEMW, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 6'd4, 1'b1, 1'b1); lit("prio_ack_exw", EXW, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0); lit("prio_ex_c2", EXW, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0); lit("prio_ex_c3", EXW, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0); lit("prio_done", NONE, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0); lit("prio_after", NONE, 1'b0, 1'b0);
        // Single-cycle ops and a bare load-use request.
        step(1'b1, 1'b1, 1'b1, 6'd1, 1'b0, 1'b0); lit("n1_id", IDW, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0); lit("n0", NONE, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0); lit("id_only", IDW, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 6'd2, 1'b0, 1'b0); lit("n2_c1", EXW, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0); lit("n2_done", NONE, 1'b1, 1'b1);
        // Requests during EX_WAIT are ignored.
        step(1'b1, 1'b0, 1'b1, 6'd3, 1'b0, 1'b0); lit("ign_c1", EXW, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 6'd7, 1'b0, 1'b0); lit("ign_c2", EXW, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0); lit("ign_done", NONE, 1'b1, 1'b1);
        // Reset mid-operation aborts without a done pulse.
        step(1'b1, 1'b0, 1'b1, 6'd10, 1'b0, 1'b0); lit("abort_c1", EXW, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0); lit("abort_rst", NONE, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0); lit("abort_after", NONE, 1'b0, 1'b0);
        // Randomized traffic checked by the model.
        for (int i = 0; i < 4000; i++) begin
            logic       r;
            logic       idr;
            logic       st;
            logic [5:0] n;
            logic       mr;
            logic       ma;
            r   = ($urandom_range(0, 99) != 0);
            idr = ($urandom_range(0, 3) == 0);
            st  = ($urandom_range(0, 4) == 0);
            n   = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63))
                                              : 6'($urandom_range(0, 8));
            mr  = ($urandom_range(0, 2) == 0);
            ma  = ($urandom_range(0, 1) == 0);
            step(r, idr, st, n, mr, ma);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
